turn_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 40 ++++
 rtl/turn_sequencer_if.sv | 33 +++
 rtl/turn_sequencer_timer.sv | 53 +++++
 rtl/turn_sequencer.sv | 169 ++++++++++++++++
 tb/tb_turn_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared Connect-4 game definitions: player codes, board size, sequencer
// states and small column helpers.
package game_pkg;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P1     = 2'b01;
    localparam logic [1:0] P2     = 2'b10;
    localparam logic [1:0] P_DRAW = 2'b11;

    localparam int N_COLS = 7;
    localparam int N_ROWS = 6;

    localparam logic [N_COLS-1:0] ALL_FULL = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MOVE,
        ISSUE,
        WAIT_ACK,
        SETTLE,
        GAME_OVER
    } seq_state_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_col(input logic [N_COLS-1:0] v);
        lowest_col = 3'd0;
        for (int c = N_COLS - 1; c >= 0; c--) begin
            if (v[c]) lowest_col = 3'(c);
        end
    endfunction

    function automatic logic [N_COLS-1:0] col_onehot(input logic [2:0] c);
        col_onehot = {{(N_COLS-1){1'b0}}, 1'b1} << c;
    endfunction

    function automatic logic [1:0] other_player(input logic [1:0] p);
        other_player = (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Bundle between the turn sequencer and the rest of the game datapath.
// slave = sequencer side, master = environment (buttons, drop block, win checker).
interface turn_sequencer_if;
    import game_pkg::*;

    logic              start;
    logic [N_COLS-1:0] p1_req;
    logic [N_COLS-1:0] p2_req;
    logic [N_COLS-1:0] col_full;
    logic [1:0]        win;
    logic              inserted;

    logic [N_COLS-1:0] pulses;
    logic [1:0]        jugador;
    logic              juego_terminado;
    logic [1:0]        winner;
    logic [3:0]        secs_left;
    logic              auto_move;
    logic              drop_err;

    modport slave (
        input  start, p1_req, p2_req, col_full, win, inserted,
        output pulses, jugador, juego_terminado, winner, secs_left,
               auto_move, drop_err
    );

    modport master (
        output start, p1_req, p2_req, col_full, win, inserted,
        input  pulses, jugador, juego_terminado, winner, secs_left,
               auto_move, drop_err
    );

endinterface

// File: rtl/turn_sequencer_timer.sv
// Per-turn countdown: a prescaler dividing the clock to seconds and a
// saturating seconds counter. expire_o flags the wrap that takes 1 -> 0.
module turn_timer #(
    parameter int CYCLES_PER_SEC = 25_000_000,
    parameter int TURN_SECONDS   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       enable_i,
    output logic [3:0] secs_left_o,
    output logic       expire_o
);

    localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    secs_q, secs_d;
    logic          wrap;

    assign wrap        = (presc_q == PW'(CYCLES_PER_SEC - 1));
    assign expire_o    = enable_i & ~load_i & wrap & (secs_q == 4'd1);
    assign secs_left_o = secs_q;

    // Next prescaler / seconds value: load wins, otherwise count while enabled.
    always_comb begin
        presc_d = presc_q;
        secs_d  = secs_q;
        if (load_i) begin
            presc_d = '0;
            secs_d  = 4'(TURN_SECONDS);
        end else if (enable_i) begin
            if (wrap) begin
                presc_d = '0;
                if (secs_q != 4'd0) secs_d = secs_q - 4'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            secs_q  <= 4'(TURN_SECONDS);
        end else begin
            presc_q <= presc_d;
            secs_q  <= secs_d;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Game-level turn controller: arbitrates column requests from the player
// whose turn it is, issues one one-hot column pulse per turn, waits for the
// drop block to acknowledge, lets the board settle, then decides win, draw
// or next turn. A countdown forces a move into the lowest free column.
module turn_sequencer
    import game_pkg::*;
#(
    parameter int         CYCLES_PER_SEC = 25_000_000,
    parameter int         TURN_SECONDS   = 10,
    parameter int         SETTLE_CYCLES  = 12_500_001,
    parameter int         ACK_TIMEOUT    = 64,
    parameter logic [1:0] FIRST_PLAYER   = 2'b01
) (
    input logic             clk,
    input logic             reset,
    turn_sequencer_if.slave bus
);

    localparam int AW = (ACK_TIMEOUT > 1)   ? $clog2(ACK_TIMEOUT)   : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_t        state_q, state_d;
    logic [2:0]        col_q, col_d;
    logic [AW-1:0]     ack_cnt_q, ack_cnt_d;
    logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
    logic [1:0]        jugador_q, jugador_d;
    logic [1:0]        winner_q, winner_d;
    logic [N_COLS-1:0] pulses_q, pulses_d;
    logic              auto_move_q, auto_move_d;
    logic              drop_err_q, drop_err_d;
    logic              over_q, over_d;

    logic              timer_load;
    logic              timer_en;
    logic              expire;
    logic [3:0]        secs_left;
    logic [N_COLS-1:0] req;

    turn_timer #(
        .CYCLES_PER_SEC (CYCLES_PER_SEC),
        .TURN_SECONDS   (TURN_SECONDS)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .load_i      (timer_load),
        .enable_i    (timer_en),
        .secs_left_o (secs_left),
        .expire_o    (expire)
    );

    // Only the current player's requests to non-full columns count.
    assign req = ((jugador_q == P1) ? bus.p1_req : bus.p2_req) & ~bus.col_full;

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        ack_cnt_d    = ack_cnt_q;
        settle_cnt_d = settle_cnt_q;
        jugador_d    = jugador_q;
        winner_d     = winner_q;
        pulses_d     = '0;
        auto_move_d  = 1'b0;
        drop_err_d   = 1'b0;
        timer_load   = 1'b0;
        timer_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = WAIT_MOVE;
                    timer_load = 1'b1;
                end
            end
            WAIT_MOVE: begin
                timer_en = 1'b1;
                if (bus.col_full == ALL_FULL) begin
                    winner_d = P_DRAW;
                    state_d  = GAME_OVER;
                end else if (req != '0) begin
                    col_d    = lowest_col(req);
                    pulses_d = col_onehot(col_d);
                    state_d  = ISSUE;
                end else if (expire) begin
                    col_d       = lowest_col(~bus.col_full);
                    pulses_d    = col_onehot(col_d);
                    auto_move_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                ack_cnt_d = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.inserted) begin
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                    drop_err_d = 1'b1;
                    state_d    = WAIT_MOVE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    if (bus.win != P_NONE) begin
                        winner_d = bus.win;
                        state_d  = GAME_OVER;
                    end else if (bus.col_full == ALL_FULL) begin
                        winner_d = P_DRAW;
                        state_d  = GAME_OVER;
                    end else begin
                        jugador_d  = other_player(jugador_q);
                        timer_load = 1'b1;
                        state_d    = WAIT_MOVE;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        over_d = (state_d == IDLE) || (state_d == GAME_OVER);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            ack_cnt_q    <= '0;
            settle_cnt_q <= '0;
            jugador_q    <= FIRST_PLAYER;
            winner_q     <= P_NONE;
            pulses_q     <= '0;
            auto_move_q  <= 1'b0;
            drop_err_q   <= 1'b0;
            over_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            ack_cnt_q    <= ack_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            jugador_q    <= jugador_d;
            winner_q     <= winner_d;
            pulses_q     <= pulses_d;
            auto_move_q  <= auto_move_d;
            drop_err_q   <= drop_err_d;
            over_q       <= over_d;
        end
    end

    assign bus.pulses          = pulses_q;
    assign bus.jugador         = jugador_q;
    assign bus.juego_terminado = over_q;
    assign bus.winner          = winner_q;
    assign bus.secs_left       = secs_left;
    assign bus.auto_move       = auto_move_q;
    assign bus.drop_err        = drop_err_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scenario bench for turn_sequencer with randomized moves checked against
// a turn-level reference model.
module tb_turn_sequencer;

    localparam int CPS = 4;
    localparam int TS  = 3;
    localparam int SC  = 5;
    localparam int AT  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    turn_sequencer_if tif();

    turn_sequencer #(
        .CYCLES_PER_SEC (CPS),
        .TURN_SECONDS   (TS),
        .SETTLE_CYCLES  (SC),
        .ACK_TIMEOUT    (AT),
        .FIRST_PLAYER   (2'b01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_player;

    // Reference model: the lowest set column as a one-hot, by two's-complement isolation.
    function automatic logic [6:0] ref_first(input logic [6:0] v);
        ref_first = v & (~v + 7'd1);
    endfunction

    function automatic logic [1:0] ref_other(input logic [1:0] p);
        ref_other = 2'(3 - p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        tif.start = 1'b0; tif.p1_req = '0; tif.p2_req = '0;
        tif.col_full = '0; tif.win = 2'b00; tif.inserted = 1'b0;
    endtask

    task automatic do_start();
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] player, input logic [6:0] mine, input logic [6:0] theirs);
        if (player == 2'b01) begin tif.p1_req = mine; tif.p2_req = theirs; end
        else begin tif.p2_req = mine; tif.p1_req = theirs; end
    endtask

    // From WAIT_ACK (counter 0): acknowledge after delay cycles, then let SETTLE run out.
    task automatic ack_and_settle(input int delay);
        repeat (delay) tick();
        tif.inserted = 1'b1;
        tick();
        tif.inserted = 1'b0;
        repeat (SC) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) tick();
        total++; if (tif.pulses !== 7'd0) begin bad++; $display("FAIL rst_pulses got=%h want=%h", tif.pulses, 7'd0); end
        total++; if (tif.jugador !== 2'b01) begin bad++; $display("FAIL rst_jugador got=%h want=%h", tif.jugador, 2'b01); end
        total++; if (tif.juego_terminado !== 1'b1) begin bad++; $display("FAIL rst_over got=%b want=1", tif.juego_terminado); end
        total++; if (tif.winner !== 2'b00) begin bad++; $display("FAIL rst_winner got=%h want=0", tif.winner); end
        total++; if (tif.secs_left !== 4'(TS)) begin bad++; $display("FAIL rst_secs got=%0d want=%0d", tif.secs_left, TS); end
        total++; if (tif.auto_move !== 1'b0 || tif.drop_err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b want=00", tif.auto_move, tif.drop_err); end
        reset = 1'b0;
        tif.p1_req = 7'h01; tif.inserted = 1'b1;
        repeat (3) tick();
        total++; if (tif.pulses !== 7'd0 || tif.juego_terminado !== 1'b1) begin bad++; $display("FAIL idle_ignore got=%h/%b want=0/1", tif.pulses, tif.juego_terminado); end
        clear_inputs();
        exp_player = 2'b01;
    endtask

    task automatic test_basic_turn();
        do_start();
        total++; if (tif.juego_terminado !== 1'b0 || tif.secs_left !== 4'(TS)) begin bad++; $display("FAIL start got=%b/%0d want=0/%0d", tif.juego_terminado, tif.secs_left, TS); end
        tif.p1_req = 7'b0001000;
        tick();
        tif.p1_req = '0;
        total++; if (tif.pulses !== 7'b0001000) begin bad++; $display("FAIL basic_pulse got=%b want=%b", tif.pulses, 7'b0001000); end
        total++; if (tif.jugador !== exp_player) begin bad++; $display("FAIL basic_jug got=%h want=%h", tif.jugador, exp_player); end
        tick();
        total++; if (tif.pulses !== 7'd0) begin bad++; $display("FAIL basic_single got=%b want=0", tif.pulses); end
        tick();
        tif.inserted = 1'b1;
        tick();
        tif.inserted = 1'b0;
        repeat (SC - 1) tick();
        total++; if (tif.jugador !== exp_player) begin bad++; $display("FAIL basic_settle_jug got=%h want=%h", tif.jugador, exp_player); end
        tick();
        exp_player = ref_other(exp_player);
        total++; if (tif.jugador !== exp_player) begin bad++; $display("FAIL basic_toggle got=%h want=%h", tif.jugador, exp_player); end
        total++; if (tif.secs_left !== 4'(TS) || tif.juego_terminado !== 1'b0) begin bad++; $display("FAIL basic_next got=%0d/%b want=%0d/0", tif.secs_left, tif.juego_terminado, TS); end
    endtask

    task automatic test_discard();
        drive_req(exp_player, 7'h00, 7'h7F);
        repeat (2) begin
            tick();
            total++; if (tif.pulses !== 7'd0) begin bad++; $display("FAIL other_player got=%b want=0", tif.pulses); end
        end
        tif.p1_req = '0; tif.p2_req = '0;
        tif.inserted = 1'b1;
        tick();
        tif.inserted = 1'b0;
        total++; if (tif.pulses !== 7'd0 || tif.jugador !== exp_player) begin bad++; $display("FAIL stray_ins got=%b/%h want=0/%h", tif.pulses, tif.jugador, exp_player); end
        tif.col_full = 7'b0000001;
        drive_req(exp_player, 7'h01, 7'h00);
        tick();
        total++; if (tif.pulses !== 7'd0) begin bad++; $display("FAIL full_col got=%b want=0", tif.pulses); end
        tif.col_full = '0;
        drive_req(exp_player, 7'b0000110, 7'h00);
        tick();
        tif.p1_req = '0; tif.p2_req = '0;
        total++; if (tif.pulses !== ref_first(7'b0000110)) begin bad++; $display("FAIL lowest got=%b want=%b", tif.pulses, ref_first(7'b0000110)); end
        tick();
        ack_and_settle(2);
        exp_player = ref_other(exp_player);
        total++; if (tif.jugador !== exp_player) begin bad++; $display("FAIL discard_next got=%h want=%h", tif.jugador, exp_player); end
    endtask

    task automatic test_random_turns();
        for (int i = 0; i < 8; i++) begin
            logic [6:0] full, mine, theirs, expect_p;
            full   = 7'($urandom_range(0, 126));
            mine   = 7'($urandom_range(1, 127));
            theirs = 7'($urandom);
            if ((mine & ~full) == 7'd0) mine = ~full;
            expect_p = ref_first(mine & ~full);
            tif.col_full = full;
            drive_req(exp_player, mine, theirs);
            tick();
            tif.p1_req = '0; tif.p2_req = '0;
            total++; if (tif.pulses !== expect_p) begin bad++; $display("FAIL rnd_pulse[%0d] got=%b want=%b", i, tif.pulses, expect_p); end
            total++; if (tif.jugador !== exp_player || tif.auto_move !== 1'b0) begin bad++; $display("FAIL rnd_jug[%0d] got=%h/%b want=%h/0", i, tif.jugador, tif.auto_move, exp_player); end
            tick();
            total++; if (tif.pulses !== 7'd0) begin bad++; $display("FAIL rnd_single[%0d] got=%b want=0", i, tif.pulses); end
            ack_and_settle($urandom_range(0, 6));
            exp_player = ref_other(exp_player);
            total++; if (tif.jugador !== exp_player || tif.secs_left !== 4'(TS)) begin bad++; $display("FAIL rnd_next[%0d] got=%h/%0d want=%h/%0d", i, tif.jugador, tif.secs_left, exp_player, TS); end
        end
        tif.col_full = '0;
    endtask

    task automatic test_timeout();
        logic [6:0] full, mine, expect_p;
        full = 7'($urandom_range(0, 126));
        expect_p = ref_first(~full);
        tif.col_full = full;
        repeat (CPS) tick();
        total++; if (tif.secs_left !== 4'(TS - 1)) begin bad++; $display("FAIL to_secs2 got=%0d want=%0d", tif.secs_left, TS - 1); end
        repeat (CPS) tick();
        total++; if (tif.secs_left !== 4'(TS - 2)) begin bad++; $display("FAIL to_secs1 got=%0d want=%0d", tif.secs_left, TS - 2); end
        repeat (CPS - 1) tick();
        total++; if (tif.pulses !== 7'd0 || tif.auto_move !== 1'b0) begin bad++; $display("FAIL to_early got=%b/%b want=0/0", tif.pulses, tif.auto_move); end
        tick();
        total++; if (tif.auto_move !== 1'b1 || tif.pulses !== expect_p) begin bad++; $display("FAIL to_auto got=%b/%b want=1/%b", tif.auto_move, tif.pulses, expect_p); end
        total++; if (tif.secs_left !== 4'd0 || tif.jugador !== exp_player) begin bad++; $display("FAIL to_secs0 got=%0d/%h want=0/%h", tif.secs_left, tif.jugador, exp_player); end
        tick();
        total++; if (tif.auto_move !== 1'b0 || tif.pulses !== 7'd0) begin bad++; $display("FAIL to_oneshot got=%b/%b want=0/0", tif.auto_move, tif.pulses); end
        tif.col_full = '0;
        ack_and_settle(1);
        exp_player = ref_other(exp_player);
        // A request landing on the expiry cycle takes precedence over the auto-move.
        repeat (TS * CPS - 1) tick();
        mine = 7'($urandom_range(2, 127));
        drive_req(exp_player, mine, 7'h00);
        tick();
        tif.p1_req = '0; tif.p2_req = '0;
        total++; if (tif.pulses !== ref_first(mine) || tif.auto_move !== 1'b0) begin bad++; $display("FAIL race got=%b/%b want=%b/0", tif.pulses, tif.auto_move, ref_first(mine)); end
        total++; if (tif.secs_left !== 4'd0) begin bad++; $display("FAIL race_secs got=%0d want=0", tif.secs_left); end
        tick();
        ack_and_settle(0);
        exp_player = ref_other(exp_player);
    endtask

    task automatic test_drop_err();
        logic [6:0] mine;
        mine = 7'($urandom_range(1, 127));
        drive_req(exp_player, mine, 7'h00);
        tick();
        tif.p1_req = '0; tif.p2_req = '0;
        total++; if (tif.pulses !== ref_first(mine)) begin bad++; $display("FAIL de_pulse got=%b want=%b", tif.pulses, ref_first(mine)); end
        tick();
        repeat (AT - 1) tick();
        total++; if (tif.drop_err !== 1'b0) begin bad++; $display("FAIL de_early got=%b want=0", tif.drop_err); end
        tick();
        total++; if (tif.drop_err !== 1'b1) begin bad++; $display("FAIL de_pulse_err got=%b want=1", tif.drop_err); end
        total++; if (tif.jugador !== exp_player || tif.secs_left !== 4'(TS)) begin bad++; $display("FAIL de_keep got=%h/%0d want=%h/%0d", tif.jugador, tif.secs_left, exp_player, TS); end
        tick();
        total++; if (tif.drop_err !== 1'b0 || tif.pulses !== 7'd0) begin bad++; $display("FAIL de_oneshot got=%b/%b want=0/0", tif.drop_err, tif.pulses); end
        drive_req(exp_player, 7'b1000000, 7'h00);
        tick();
        tif.p1_req = '0; tif.p2_req = '0;
        total++; if (tif.pulses !== 7'b1000000) begin bad++; $display("FAIL de_retry got=%b want=%b", tif.pulses, 7'b1000000); end
        tick();
        ack_and_settle(3);
        exp_player = ref_other(exp_player);
        total++; if (tif.jugador !== exp_player) begin bad++; $display("FAIL de_next got=%h want=%h", tif.jugador, exp_player); end
    endtask

    task automatic test_win();
        drive_req(exp_player, 7'b0010000, 7'h00);
        tick();
        tif.p1_req = '0; tif.p2_req = '0;
        tick();
        tif.inserted = 1'b1;
        tif.win = 2'b10;
        tick();
        tif.inserted = 1'b0;
        repeat (SC - 1) tick();
        total++; if (tif.winner !== 2'b00 || tif.juego_terminado !== 1'b0) begin bad++; $display("FAIL win_early got=%h/%b want=0/0", tif.winner, tif.juego_terminado); end
        tick();
        total++; if (tif.winner !== 2'b10 || tif.juego_terminado !== 1'b1) begin bad++; $display("FAIL win got=%h/%b want=2/1", tif.winner, tif.juego_terminado); end
        total++; if (tif.jugador !== exp_player) begin bad++; $display("FAIL win_jug got=%h want=%h", tif.jugador, exp_player); end
        tif.win = 2'b00;
        tif.start = 1'b1; tif.p1_req = 7'h7F; tif.p2_req = 7'h7F; tif.inserted = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (tif.pulses !== 7'd0 || tif.winner !== 2'b10 || tif.juego_terminado !== 1'b1) begin bad++; $display("FAIL over_hold[%0d] got=%b/%h/%b want=0/2/1", k, tif.pulses, tif.winner, tif.juego_terminado); end
        end
        clear_inputs();
    endtask

    task automatic test_draw();
        reset = 1'b1; tick(); reset = 1'b0;
        exp_player = 2'b01;
        do_start();
        tif.p1_req = 7'h01;
        tick();
        tif.p1_req = '0;
        total++; if (tif.pulses !== 7'h01) begin bad++; $display("FAIL draw_pulse got=%b want=%b", tif.pulses, 7'h01); end
        tick();
        tif.inserted = 1'b1;
        tick();
        tif.inserted = 1'b0;
        tif.col_full = 7'h7F;
        repeat (SC) tick();
        total++; if (tif.winner !== 2'b11 || tif.juego_terminado !== 1'b1) begin bad++; $display("FAIL draw_settle got=%h/%b want=3/1", tif.winner, tif.juego_terminado); end
        clear_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        do_start();
        tif.col_full = 7'h7F; tif.p1_req = 7'h01;
        tick();
        clear_inputs();
        total++; if (tif.pulses !== 7'd0 || tif.winner !== 2'b11 || tif.juego_terminado !== 1'b1) begin bad++; $display("FAIL draw_wait got=%b/%h/%b want=0/3/1", tif.pulses, tif.winner, tif.juego_terminado); end
    endtask

    task automatic test_reset_midturn();
        reset = 1'b1; tick(); reset = 1'b0;
        exp_player = 2'b01;
        do_start();
        tif.p1_req = 7'h04;
        tick();
        tif.p1_req = '0;
        tick();
        ack_and_settle(1);
        exp_player = ref_other(exp_player);
        repeat (CPS + 1) tick();
        total++; if (tif.secs_left !== 4'(TS - 1)) begin bad++; $display("FAIL mid_secs got=%0d want=%0d", tif.secs_left, TS - 1); end
        drive_req(exp_player, 7'h20, 7'h00);
        tick();
        tif.p1_req = '0; tif.p2_req = '0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (tif.pulses !== 7'd0 || tif.jugador !== 2'b01 || tif.juego_terminado !== 1'b1) begin bad++; $display("FAIL mid_rst got=%b/%h/%b want=0/1/1", tif.pulses, tif.jugador, tif.juego_terminado); end
        total++; if (tif.secs_left !== 4'(TS) || tif.winner !== 2'b00) begin bad++; $display("FAIL mid_rst_secs got=%0d/%h want=%0d/0", tif.secs_left, tif.winner, TS); end
        @(negedge clk);
        reset = 1'b0;
        tif.inserted = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (tif.pulses !== 7'd0 || tif.juego_terminado !== 1'b1) begin bad++; $display("FAIL post_rst[%0d] got=%b/%b want=0/1", k, tif.pulses, tif.juego_terminado); end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_turn();
        test_discard();
        test_random_turns();
        test_timeout();
        test_drop_err();
        test_win();
        test_draw();
        test_reset_midturn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
